cdc_req_launcher: RTL and testbench

//   Source-side (clk_A) launcher feeding the multi-bit clk_A->clk_B synchronizer.

---
 rtl/cdc_req_launcher.sv | 105 ++++++++++
 tb/tb_cdc_req_launcher.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_req_launcher.sv
// Source-side launcher for the clk_A->clk_B multi-bit synchronizer: holds each word on tx_data
// and runs a 4-phase req/ack handshake. Optional handshake watchdog under `CDC_TX_TIMEOUT_EN`.
module cdc_req_launcher #(
    parameter int WIDTH          = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk_A,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_req,
    input  logic             ack_async,
    output logic             busy,
    output logic             err,
    input  logic             err_clr
);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic                   req_timeout;
    logic                   drop_timeout;

    always_ff @(posedge clk_A or negedge rst_n) begin
        if (!rst_n) ack_sync <= '0;
        else        ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_async};
    end

    assign ack_s   = ack_sync[SYNC_STAGES-1];
    // A stale ack still high from the last transfer must drain before a new word is taken.
    assign s_ready = (state == IDLE) && !ack_s;
    assign busy    = (state != IDLE);

`ifdef CDC_TX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          cnt_last;

    assign cnt_last     = (cnt == CNT_LAST);
    assign req_timeout  = (state == REQ)  && !ack_s && cnt_last;
    assign drop_timeout = (state == DROP) &&  ack_s && cnt_last;

    // Counter restarts whenever REQ or DROP is entered; leaving either state always clears it.
    always_ff @(posedge clk_A or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            case (state)
                REQ:     cnt <= (ack_s || cnt_last)  ? '0 : cnt + 1'b1;
                DROP:    cnt <= (!ack_s || cnt_last) ? '0 : cnt + 1'b1;
                default: cnt <= '0;
            endcase
            if (err_clr)                     err <= 1'b0;
            if (req_timeout || drop_timeout) err <= 1'b1;
        end
    end
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign req_timeout    = 1'b0;
    assign drop_timeout   = 1'b0;
    assign err            = 1'b0;
`endif

    always_ff @(posedge clk_A or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx_data <= '0;
            tx_req  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_valid && s_ready) begin
                        tx_data <= s_data;
                        tx_req  <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (ack_s || req_timeout) begin
                        tx_req <= 1'b0;
                        state  <= DROP;
                    end
                end
                DROP: begin
                    if (!ack_s || drop_timeout) state <= IDLE;
                end
                default: begin
                    tx_req <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_req_launcher.sv
// Directed bench for cdc_req_launcher; timeout scenario runs only when CDC_TX_TIMEOUT_EN is defined.
module tb_cdc_req_launcher;

    localparam int WIDTH = 4;

    logic             clk_A = 1'b0;
    logic             rst_n = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [WIDTH-1:0] s_data = '0;
    logic [WIDTH-1:0] tx_data;
    logic             tx_req;
    logic             ack_async = 1'b0;
    logic             busy;
    logic             err;
    logic             err_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    cdc_req_launcher #(.WIDTH(WIDTH), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
        .clk_A(clk_A), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .tx_data(tx_data), .tx_req(tx_req), .ack_async(ack_async), .busy(busy),
        .err(err), .err_clr(err_clr)
    );

    always #5 clk_A = ~clk_A;

    // tx_data must hold while the far side may be sampling it.
    logic             prev_busy = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    always @(negedge clk_A or negedge rst_n) begin
        if (!rst_n) begin
            prev_busy = 1'b0;
        end else begin
            if (prev_busy) begin
                checks++;
                if (tx_data !== prev_data) begin
                    errors++;
                    $display("FAIL t3_tx_data_stable: tx_data=%h was %h while busy", tx_data, prev_data);
                end
            end
            prev_busy = busy;
            prev_data = tx_data;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_A);
        #1;
    endtask

    task automatic finish_handshake();
        ack_async = 1'b1;
        tick(3);
        ack_async = 1'b0;
        tick(3);
    endtask

    task automatic test_reset();
        checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL t1_rst_req: got %b want 0", tx_req); end
        checks++; if (tx_data !== 4'h0) begin errors++; $display("FAIL t1_rst_data: got %h want 0", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_rst_busy: got %b want 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL t1_rst_err: got %b want 0", err); end
        rst_n = 1'b1;
        tick();
        s_valid = 1'b1; s_data = 4'h9;
        tick();
        s_valid = 1'b0;
        checks++; if (tx_req !== 1'b1) begin errors++; $display("FAIL t1_pre_req: got %b want 1", tx_req); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL t1_mid_req: got %b want 0", tx_req); end
        checks++; if (tx_data !== 4'h0) begin errors++; $display("FAIL t1_mid_data: got %h want 0", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_mid_busy: got %b want 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL t1_mid_err: got %b want 0", err); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL t1_post_ready: got %b want 1", s_ready); end
    endtask

    task automatic test_handshake();
        s_valid = 1'b1; s_data = 4'hA;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL t2_ready: got %b want 1", s_ready); end
        tick();
        s_valid = 1'b0; s_data = 4'h0;
        checks++; if (tx_req !== 1'b1) begin errors++; $display("FAIL t2_req_rise: got %b want 1", tx_req); end
        checks++; if (tx_data !== 4'hA) begin errors++; $display("FAIL t2_data: got %h want a", tx_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t2_busy: got %b want 1", busy); end
        tick(4);
        checks++; if (tx_req !== 1'b1) begin errors++; $display("FAIL t2_req_hold: got %b want 1", tx_req); end
        ack_async = 1'b1;
        tick();
        checks++; if (tx_req !== 1'b1) begin errors++; $display("FAIL t2_req_e1: got %b want 1", tx_req); end
        tick();
        checks++; if (tx_req !== 1'b1) begin errors++; $display("FAIL t2_req_e2: got %b want 1", tx_req); end
        tick();
        checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL t2_req_fall: got %b want 0", tx_req); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t2_drop_busy: got %b want 1", busy); end
        checks++; if (tx_data !== 4'hA) begin errors++; $display("FAIL t2_drop_data: got %h want a", tx_data); end
        ack_async = 1'b0;
        tick(2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t2_drop_wait: got %b want 1", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t2_idle: got %b want 0", busy); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL t2_idle_ready: got %b want 1", s_ready); end
    endtask

    task automatic test_back_to_back();
        s_valid = 1'b1; s_data = 4'h3;
        tick();
        checks++; if (tx_data !== 4'h3) begin errors++; $display("FAIL t3_first: got %h want 3", tx_data); end
        s_data = 4'h5;
        tick(2);
        checks++; if (tx_data !== 4'h3) begin errors++; $display("FAIL t3_ignore: got %h want 3", tx_data); end
        ack_async = 1'b1;
        tick(3);
        ack_async = 1'b0;
        tick(2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t3_drop: got %b want 1", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t3_idle: got %b want 0", busy); end
        checks++; if (tx_data !== 4'h3) begin errors++; $display("FAIL t3_idle_data: got %h want 3", tx_data); end
        tick();
        s_valid = 1'b0;
        checks++; if (tx_data !== 4'h5) begin errors++; $display("FAIL t3_second: got %h want 5", tx_data); end
        checks++; if (tx_req !== 1'b1) begin errors++; $display("FAIL t3_second_req: got %b want 1", tx_req); end
        finish_handshake();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t3_done: got %b want 0", busy); end
    endtask

    task automatic test_stale_ack();
        rst_n = 1'b0; ack_async = 1'b1; s_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(2);
        s_valid = 1'b1; s_data = 4'h7;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL t4_stale_ready: got %b want 0", s_ready); end
        tick(3);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t4_no_accept: got %b want 0", busy); end
        checks++; if (tx_data !== 4'h0) begin errors++; $display("FAIL t4_no_load: got %h want 0", tx_data); end
        ack_async = 1'b0;
        tick();
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL t4_ready_e1: got %b want 0", s_ready); end
        tick();
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL t4_ready_e2: got %b want 1", s_ready); end
        tick();
        s_valid = 1'b0;
        checks++; if (tx_data !== 4'h7) begin errors++; $display("FAIL t4_accept: got %h want 7", tx_data); end
        finish_handshake();
    endtask

`ifdef CDC_TX_TIMEOUT_EN
    task automatic test_timeout();
        s_valid = 1'b1; s_data = 4'hC;
        tick();
        s_valid = 1'b0;
        tick(15);
        checks++; if (tx_req !== 1'b1) begin errors++; $display("FAIL t5_req_hold: got %b want 1", tx_req); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL t5_err_early: got %b want 0", err); end
        tick();
        checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL t5_req_fall: got %b want 0", tx_req); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL t5_err_set: got %b want 1", err); end
        tick(4);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_idle: got %b want 0", busy); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL t5_sticky: got %b want 1", err); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL t5_clr: got %b want 0", err); end
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        tick(15);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL t5_set_wins: got %b want 1", err); end
        tick(2);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL t5_clr2: got %b want 0", err); end
    endtask
`else
    task automatic test_no_timeout();
        int bad_cycle;
        bad_cycle = -1;
        s_valid = 1'b1; s_data = 4'h6;
        tick();
        s_valid = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (bad_cycle < 0 && (tx_req !== 1'b1 || err !== 1'b0)) bad_cycle = i;
            tick();
        end
        checks++; if (bad_cycle != -1) begin errors++; $display("FAIL t6_wait: cycle %0d tx_req=%b err=%b want 1/0", bad_cycle, tx_req, err); end
        finish_handshake();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_done: got %b want 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL t6_err: got %b want 0", err); end
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_handshake();
        test_back_to_back();
        test_stale_ack();
`ifdef CDC_TX_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 time units");
        $fatal(1);
    end

endmodule
